// File: rtl/audio_sigmadelta_mc.sv
// audio_sigmadelta_mc: multi-channel 1-bit sigma-delta audio DAC.
// Each channel holds a signed sample, converts it to an offset-binary level,
// scales it by a shared mute-ramp gain and feeds a 1st- or 2nd-order
// modulator. A four-state ramp FSM walks the gain between full scale and
// silence so muting never produces a step in the output level.
//
// Handshake: a sample transfers on any rising clk edge where sample_valid and
// sample_ready are both high. sample_ready is simply !reset, so a producer may
// present a new word every cycle and valid never has to wait on ready.
//
// Debug: dbg_state_o carries the ramp state (0 UNMUTED, 1 RAMP_DOWN,
// 2 MUTED, 3 RAMP_UP) and dbg_gain_o the current gain g.
module audio_sigmadelta_mc #(
  parameter int CHANNELS   = 2,
  parameter int AUDIO_BITS = 10,
  parameter int ORDER      = 1,
  parameter int GAIN_BITS  = 4,
  parameter int RAMP_DIV   = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           ce,
  input  logic                           sample_valid,
  output logic                           sample_ready,
  input  logic [CHANNELS*AUDIO_BITS-1:0] sample_data,
  input  logic                           mute,
  output logic                           muted,
  output logic [CHANNELS-1:0]            q,
  output logic [1:0]                     dbg_state_o,
  output logic [GAIN_BITS:0]             dbg_gain_o
);

  localparam int GW = GAIN_BITS + 1;
  localparam int DW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int PW = AUDIO_BITS + GW + 1;
  localparam int IW = AUDIO_BITS + 4;
  localparam int EW = IW + 2;

  localparam logic [GW-1:0] G_MAX    = {1'b1, {GAIN_BITS{1'b0}}};
  localparam logic [DW-1:0] DIV_LAST = DW'(RAMP_DIV - 1);

  typedef enum logic [1:0] {
    ST_UNMUTED   = 2'd0,
    ST_RAMP_DOWN = 2'd1,
    ST_MUTED     = 2'd2,
    ST_RAMP_UP   = 2'd3
  } ramp_state_e;

  ramp_state_e          state_q, state_d;
  logic [GW-1:0]        gain_q, gain_d;
  logic [DW-1:0]        div_q, div_d, div_cur;
  logic [AUDIO_BITS-1:0] samp_q [CHANNELS];

  // Clamp a widened integrator sum back into IW bits instead of wrapping.
  function automatic logic signed [IW-1:0] sat(input logic signed [EW-1:0] v);
    logic signed [IW-1:0] r;
    if (v[EW-1:IW-1] == 3'b000 || v[EW-1:IW-1] == 3'b111) r = v[IW-1:0];
    else if (v[EW-1])                                     r = {1'b1, {(IW-1){1'b0}}};
    else                                                  r = {1'b0, {(IW-1){1'b1}}};
    return r;
  endfunction

  assign sample_ready = ~reset;
  assign muted        = (state_q == ST_MUTED);
  assign dbg_state_o  = state_q;
  assign dbg_gain_o   = gain_q;

  // Ramp FSM state, gain and divider registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_UNMUTED;
      gain_q  <= G_MAX;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
      div_q   <= div_d;
    end
  end

  // Ramp next-state: the ce that enters a ramp state is its first divider
  // pulse, so a full ramp is exactly 2^GAIN_BITS * RAMP_DIV ce pulses and a
  // reversal mid-ramp keeps g and restarts the divider.
  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    div_d   = div_q;
    div_cur = '0;
    if (ce) begin
      if (mute) begin
        div_cur = (state_q == ST_RAMP_DOWN) ? div_q : '0;
        if (gain_q == '0) begin
          state_d = ST_MUTED;
          div_d   = '0;
        end else if (div_cur == DIV_LAST) begin
          gain_d  = gain_q - 1'b1;
          div_d   = '0;
          state_d = (gain_q == GW'(1)) ? ST_MUTED : ST_RAMP_DOWN;
        end else begin
          div_d   = div_cur + 1'b1;
          state_d = ST_RAMP_DOWN;
        end
      end else begin
        div_cur = (state_q == ST_RAMP_UP) ? div_q : '0;
        if (gain_q == G_MAX) begin
          state_d = ST_UNMUTED;
          div_d   = '0;
        end else if (div_cur == DIV_LAST) begin
          gain_d  = gain_q + 1'b1;
          div_d   = '0;
          state_d = (gain_q == G_MAX - 1'b1) ? ST_UNMUTED : ST_RAMP_UP;
        end else begin
          div_d   = div_cur + 1'b1;
          state_d = ST_RAMP_UP;
        end
      end
    end
  end

  // Sample holding registers: all channels latch together, independent of ce.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) samp_q[c] <= '0;
    end else if (sample_valid && sample_ready) begin
      for (int c = 0; c < CHANNELS; c++)
        samp_q[c] <= sample_data[c*AUDIO_BITS +: AUDIO_BITS];
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic signed [PW-1:0]  prod;
    logic [AUDIO_BITS-1:0] x;
    logic                  unused_prod;
    logic                  q_q;

    // (u - mid) is just the signed sample, so scale it directly by g.
    assign prod = PW'($signed(samp_q[c])) * $signed({{(PW-GW){1'b0}}, gain_q});
    // Bits [G+AB-1:G] are prod >>> GAIN_BITS; adding mid modulo 2^AB is an
    // MSB flip and the scaled value always lies in -mid..mid-1.
    assign x = {~prod[GAIN_BITS+AUDIO_BITS-1], prod[GAIN_BITS+AUDIO_BITS-2:GAIN_BITS]};
    assign unused_prod = ^{prod[PW-1:GAIN_BITS+AUDIO_BITS], prod[GAIN_BITS-1:0]};
    assign q[c] = q_q;

    if (ORDER == 2) begin : g_o2
      logic signed [IW-1:0] i1_q, i2_q, i1_d, i2_d;
      logic signed [EW-1:0] fb, xe, i1_sum, i2_sum;

      assign fb     = q_q ? EW'(2**AUDIO_BITS - 1) : '0;
      assign xe     = $signed({{(EW-AUDIO_BITS){1'b0}}, x});
      assign i1_sum = EW'(i1_q) + xe - fb;
      assign i1_d   = sat(i1_sum);
      assign i2_sum = EW'(i2_q) + EW'(i1_d) - fb;
      assign i2_d   = sat(i2_sum);

      // Two saturating integrators; output bit is the sign of the new i2.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          i1_q <= '0;
          i2_q <= '0;
          q_q  <= 1'b0;
        end else if (ce) begin
          i1_q <= i1_d;
          i2_q <= i2_d;
          q_q  <= ~i2_d[IW-1];
        end
      end
    end else begin : g_o1
      logic [AUDIO_BITS-1:0] acc_q;
      logic [AUDIO_BITS:0]   sum;

      assign sum = {1'b0, acc_q} + {1'b0, x};

      // First-order accumulator; the carry out is the output bit.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          acc_q <= '0;
          q_q   <= 1'b0;
        end else if (ce) begin
          acc_q <= sum[AUDIO_BITS-1:0];
          q_q   <= sum[AUDIO_BITS];
        end
      end
    end
  end

endmodule
